// File: rtl/myfilter_i2c_slave.sv
// I2C slave front-end for the filter programming path: write frames become a
// strobed byte stream, read transfers pull bytes from the loader on request.
module myfilter_i2c_slave #(
  parameter logic [6:0] I2C_ADDRESS = 7'b1111000,
  parameter int         FRAME_BYTES = 20,
  localparam int        IW          = $clog2(FRAME_BYTES),
  localparam int        CW          = $clog2(FRAME_BYTES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          scl_in,
  input  logic          sda_in,
  output logic          sda_out,
  output logic [7:0]    rx_data,
  output logic          rx_valid,
  output logic [IW-1:0] rx_index,
  output logic          tx_req,
  input  logic [7:0]    tx_data,
  output logic          frame_ok,
  output logic          busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0, HRX = 3'd1, HACK = 3'd2, RX = 3'd3,
    RACK = 3'd4, TX = 3'd5, TACK = 3'd6
  } i2c_fsm_t;

  localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME_BYTES);

  logic          scl_s1_q, scl_s2_q, scl_p_q, sda_s1_q, sda_s2_q, sda_p_q;
  i2c_fsm_t      state_q, state_d;
  logic [2:0]    bit_q, bit_d;
  logic [CW-1:0] byte_q, byte_d;
  logic [7:0]    sh_q, sh_d;
  logic          done_q, done_d;
  logic          rej_q, rej_d;
  logic          sda_out_q, sda_out_d, rx_valid_q, rx_valid_d;
  logic          tx_req_q, tx_req_d, frame_ok_q, frame_ok_d, busy_q, busy_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic [IW-1:0] rx_index_q, rx_index_d;
  logic          scl_rise_s, scl_fall_s, start_s, stop_s;

  assign scl_rise_s = scl_s2_q & ~scl_p_q;
  assign scl_fall_s = ~scl_s2_q & scl_p_q;
  assign start_s    = scl_s2_q & sda_p_q & ~sda_s2_q;
  assign stop_s     = scl_s2_q & ~sda_p_q & sda_s2_q;

  // Next-state and output computation; START/STOP take priority over bit events.
  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    sh_d       = sh_q;
    done_d     = done_q;
    rej_d      = rej_q;
    sda_out_d  = sda_out_q;
    rx_data_d  = rx_data_q;
    rx_index_d = rx_index_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    frame_ok_d = 1'b0;
    if (start_s) begin
      state_d   = HRX;
      bit_d     = 3'd0;
      byte_d    = '0;
      sda_out_d = 1'b1;
      done_d    = 1'b0;
      rej_d     = 1'b0;
    end else if (stop_s) begin
      state_d    = IDLE;
      sda_out_d  = 1'b1;
      done_d     = 1'b0;
      rej_d      = 1'b0;
      frame_ok_d = ((state_q == RX) || (state_q == RACK)) && (byte_q == FRAME_CNT);
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        HRX: begin
          if (scl_rise_s && !done_q) begin
            sh_d = {sh_q[6:0], sda_s2_q};
            if (bit_q == 3'd7) done_d = 1'b1;
            else               bit_d  = bit_q + 3'd1;
          end else if (scl_fall_s && done_q) begin
            done_d = 1'b0;
            bit_d  = 3'd0;
            if (sh_q[7:1] == I2C_ADDRESS) begin
              state_d   = HACK;
              sda_out_d = 1'b0;
            end else begin
              state_d   = IDLE;
              sda_out_d = 1'b1;
            end
          end else begin
            state_d = HRX;
          end
        end
        HACK: begin
          if (scl_rise_s) begin
            tx_req_d = sh_q[0];
          end else if (scl_fall_s) begin
            bit_d = 3'd0;
            if (sh_q[0]) begin
              state_d   = TX;
              sh_d      = tx_data;
              sda_out_d = tx_data[7];
            end else begin
              state_d   = RX;
              sda_out_d = 1'b1;
            end
          end else begin
            state_d = HACK;
          end
        end
        RX: begin
          if (scl_rise_s && !done_q) begin
            sh_d = {sh_q[6:0], sda_s2_q};
            if (bit_q == 3'd7) begin
              done_d = 1'b1;
              if (byte_q < FRAME_CNT) begin
                rx_data_d  = {sh_q[6:0], sda_s2_q};
                rx_index_d = byte_q[IW-1:0];
                rx_valid_d = 1'b1;
                byte_d     = byte_q + CW'(1);
                rej_d      = 1'b0;
              end else begin
                rej_d = 1'b1;
              end
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end else if (scl_fall_s && done_q) begin
            done_d = 1'b0;
            if (rej_q) begin
              state_d   = IDLE;
              sda_out_d = 1'b1;
              rej_d     = 1'b0;
            end else begin
              state_d   = RACK;
              sda_out_d = 1'b0;
            end
          end else begin
            state_d = RX;
          end
        end
        RACK: begin
          if (scl_fall_s) begin
            state_d   = RX;
            sda_out_d = 1'b1;
            bit_d     = 3'd0;
          end else begin
            state_d = RACK;
          end
        end
        TX: begin
          // bit_q counts bits already on the wire; bit 7 went out at entry.
          if (scl_fall_s) begin
            if (bit_q == 3'd7) begin
              state_d   = TACK;
              sda_out_d = 1'b1;
            end else begin
              bit_d     = bit_q + 3'd1;
              sda_out_d = sh_q[6];
              sh_d      = {sh_q[6:0], 1'b0};
            end
          end else begin
            state_d = TX;
          end
        end
        TACK: begin
          if (scl_rise_s && !done_q) begin
            if (!sda_s2_q) begin
              tx_req_d = 1'b1;
              done_d   = 1'b1;
            end else begin
              state_d   = IDLE;
              sda_out_d = 1'b1;
            end
          end else if (scl_fall_s && done_q) begin
            done_d    = 1'b0;
            state_d   = TX;
            sh_d      = tx_data;
            sda_out_d = tx_data[7];
            bit_d     = 3'd0;
          end else begin
            state_d = TACK;
          end
        end
        default: begin
          state_d   = IDLE;
          sda_out_d = 1'b1;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // Pin synchronizers plus all state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_p_q    <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_p_q    <= 1'b1;
      state_q    <= IDLE;
      bit_q      <= 3'd0;
      byte_q     <= '0;
      sh_q       <= 8'd0;
      done_q     <= 1'b0;
      rej_q      <= 1'b0;
      sda_out_q  <= 1'b1;
      rx_data_q  <= 8'd0;
      rx_index_q <= '0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      frame_ok_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      scl_s1_q   <= scl_in;
      scl_s2_q   <= scl_s1_q;
      scl_p_q    <= scl_s2_q;
      sda_s1_q   <= sda_in;
      sda_s2_q   <= sda_s1_q;
      sda_p_q    <= sda_s2_q;
      state_q    <= state_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      sh_q       <= sh_d;
      done_q     <= done_d;
      rej_q      <= rej_d;
      sda_out_q  <= sda_out_d;
      rx_data_q  <= rx_data_d;
      rx_index_q <= rx_index_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      frame_ok_q <= frame_ok_d;
      busy_q     <= busy_d;
    end
  end

  assign sda_out  = sda_out_q;
  assign rx_data  = rx_data_q;
  assign rx_index = rx_index_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign frame_ok = frame_ok_q;
  assign busy     = busy_q;

endmodule
